// File: rtl/mem_access_unit.sv
// Purpose: FSM-driven memory access unit with lane steering, load extension, alignment check, MOC timeout.
// Latency: req edge to done = 3 cycles minimum (CHECK, ACCESS, DONE) plus 1 per MOC wait cycle.
// Backpressure: req is ignored while busy; the memory stalls the unit by holding mem_moc low, up to TIMEOUT cycles.
// Option: MAU_BIG_ENDIAN_EN selects big-endian lane mapping (byte offset 0 = MSBs); default is little-endian.
module mem_access_unit #(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 32,
  parameter int TIMEOUT = 15
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                req,
  input  logic                rw,
  input  logic [1:0]          size,
  input  logic                unsign,
  input  logic [ADDR_W-1:0]   addr,
  input  logic [DATA_W-1:0]   wdata,
  output logic                busy,
  output logic                done,
  output logic                err,
  output logic [DATA_W-1:0]   rdata,
  output logic                mem_en,
  output logic                mem_rw,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_be,
  input  logic [DATA_W-1:0]   mem_rdata,
  input  logic                mem_moc
);

  localparam int NB   = DATA_W / 8;
  localparam int OFFW = $clog2(NB);
  localparam int SHW  = OFFW + 3;
  localparam logic [SHW-1:0] BYTE_TOP = SHW'(DATA_W - 8);
  localparam logic [SHW-1:0] HALF_TOP = SHW'(DATA_W - 16);
  localparam logic [7:0]     CNT_LAST = 8'(TIMEOUT - 1);

`ifdef MAU_BIG_ENDIAN_EN
  localparam bit BIG_END = 1'b1;
`else
  localparam bit BIG_END = 1'b0;
`endif

  typedef enum logic [2:0] {IDLE, CHECK, ACCESS, DONE, ERR} state_t;

  state_t            state;
  logic [OFFW-1:0]   marOff;     // byte offset part of the MAR
  logic [1:0]        sizeQ;
  logic              unsignQ;
  logic [DATA_W-1:0] wdataQ;
  logic [7:0]        waitCnt;

  logic [SHW-1:0]    offBits;
  logic [SHW-1:0]    shiftBits;
  logic [NB-1:0]     beBase;
  logic [DATA_W-1:0] wdataSized;
  logic              misaligned;
  logic [NB-1:0]     beNext;
  logic [DATA_W-1:0] wdataNext;
  logic [DATA_W-1:0] loadField;
  logic [DATA_W-1:0] loadExt;

  // Lane steering, alignment check and load extension from the latched request
  always_comb begin
    offBits    = {marOff, 3'b000};
    shiftBits  = '0;
    beBase     = '1;
    wdataSized = wdataQ;
    case (sizeQ)
      2'b00: begin
        shiftBits  = BIG_END ? (BYTE_TOP - offBits) : offBits;
        beBase     = NB'(1);
        wdataSized = DATA_W'(wdataQ[7:0]);
      end
      2'b01: begin
        shiftBits  = BIG_END ? (HALF_TOP - offBits) : offBits;
        beBase     = NB'(3);
        wdataSized = DATA_W'(wdataQ[15:0]);
      end
      default: begin
        shiftBits  = '0;
        beBase     = '1;
        wdataSized = wdataQ;
      end
    endcase
    misaligned = (sizeQ == 2'b11) ||
                 ((sizeQ == 2'b01) && marOff[0]) ||
                 ((sizeQ == 2'b10) && (marOff != '0));
    beNext     = beBase << shiftBits[SHW-1:3];
    wdataNext  = wdataSized << shiftBits;
    loadField  = mem_rdata >> shiftBits;
    case (sizeQ)
      2'b00:   loadExt = {{(DATA_W-8){~unsignQ & loadField[7]}}, loadField[7:0]};
      2'b01:   loadExt = {{(DATA_W-16){~unsignQ & loadField[15]}}, loadField[15:0]};
      default: loadExt = loadField;
    endcase
  end

  // Control FSM; every output is registered and set on the transition into its state
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      marOff    <= '0;
      sizeQ     <= '0;
      unsignQ   <= 1'b0;
      wdataQ    <= '0;
      waitCnt   <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      rdata     <= '0;
      mem_en    <= 1'b0;
      mem_rw    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_be    <= '0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      case (state)
        IDLE: begin
          if (req) begin
            marOff   <= addr[OFFW-1:0];
            sizeQ    <= size;
            unsignQ  <= unsign;
            wdataQ   <= wdata;
            mem_rw   <= rw;
            mem_addr <= {addr[ADDR_W-1:OFFW], {OFFW{1'b0}}};
            busy     <= 1'b1;
            state    <= CHECK;
          end
        end
        CHECK: begin
          if (misaligned) begin
            err   <= 1'b1;
            state <= ERR;
          end else begin
            mem_be    <= beNext;
            mem_wdata <= wdataNext;
            waitCnt   <= '0;
            mem_en    <= 1'b1;
            state     <= ACCESS;
          end
        end
        ACCESS: begin
          if (mem_moc) begin
            if (mem_rw) rdata <= loadExt;
            mem_en <= 1'b0;
            done   <= 1'b1;
            state  <= DONE;
          end else if (waitCnt == CNT_LAST) begin
            mem_en <= 1'b0;
            err    <= 1'b1;
            state  <= ERR;
          end else begin
            waitCnt <= waitCnt + 8'd1;
          end
        end
        DONE, ERR: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy   <= 1'b0;
          mem_en <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Purpose: directed table-driven bench for mem_access_unit (DATA_W=32) plus reset and held-req sequences.
// Latency: drives one access at a time and measures edges from the req-sampling edge to done/err.
// Backpressure: a small memory model raises mem_moc after a per-vector number of ACCESS wait cycles.
module tb_mem_access_unit;

  localparam logic [31:0] MEM_WORD = 32'h80FF1234;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        req = 1'b0;
  logic        rw = 1'b0;
  logic [1:0]  size = 2'b00;
  logic        unsign = 1'b0;
  logic [31:0] addr = '0;
  logic [31:0] wdata = '0;
  logic [31:0] mem_rdata = MEM_WORD;
  logic        mem_moc = 1'b0;

  logic        busy0, done0, err0, memEn0, memRw0;
  logic [31:0] rdata0, memAddr0, memWdata0;
  logic [3:0]  memBe0;
  logic        busy1, done1, err1, memEn1, memRw1;
  logic [31:0] rdata1, memAddr1, memWdata1;
  logic [3:0]  memBe1;

  int nCmp = 0;
  int nBad = 0;

  always #5 clk = ~clk;

  mem_access_unit #(.DATA_W(32), .ADDR_W(32), .TIMEOUT(15)) u0 (
    .clk(clk), .reset(reset), .req(req), .rw(rw), .size(size), .unsign(unsign),
    .addr(addr), .wdata(wdata), .busy(busy0), .done(done0), .err(err0), .rdata(rdata0),
    .mem_en(memEn0), .mem_rw(memRw0), .mem_addr(memAddr0), .mem_wdata(memWdata0),
    .mem_be(memBe0), .mem_rdata(mem_rdata), .mem_moc(mem_moc)
  );

  mem_access_unit #(.DATA_W(32), .ADDR_W(32), .TIMEOUT(4)) u1 (
    .clk(clk), .reset(reset), .req(req), .rw(rw), .size(size), .unsign(unsign),
    .addr(addr), .wdata(wdata), .busy(busy1), .done(done1), .err(err1), .rdata(rdata1),
    .mem_en(memEn1), .mem_rw(memRw1), .mem_addr(memAddr1), .mem_wdata(memWdata1),
    .mem_be(memBe1), .mem_rdata(mem_rdata), .mem_moc(mem_moc)
  );

  typedef struct {
    logic        rw;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          waits;
    logic        t4;        // observe the TIMEOUT=4 instance
    logic        expDone;
    logic        expErr;
    logic        expEn;
    int          expLat;
    logic [31:0] expRdata;
    logic [3:0]  expBe;
    logic [31:0] expWdata;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    nCmp++;
    if (act !== exp) begin
      nBad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic r, input logic [1:0] sz, input logic u,
                              input logic [31:0] a, input logic [31:0] wd, input int w,
                              input logic t4, input logic eD, input logic eE, input logic eEn,
                              input int lat, input logic [31:0] rd, input logic [3:0] be,
                              input logic [31:0] ewd);
    vec_t v;
    v.rw = r; v.size = sz; v.uns = u; v.addr = a; v.wdata = wd; v.waits = w; v.t4 = t4;
    v.expDone = eD; v.expErr = eE; v.expEn = eEn; v.expLat = lat;
    v.expRdata = rd; v.expBe = be; v.expWdata = ewd;
    return v;
  endfunction

  task automatic waitIdle();
    int n;
    n = 0;
    mem_moc = 1'b0;
    req = 1'b0;
    while ((busy0 || busy1) && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (busy0 || busy1) chk("idle_bound", 64'd1, 64'd0);
  endtask

  task automatic runVec(input int idx, input vec_t v);
    int lat, acc;
    logic sawDone, sawErr, sawEn;
    logic [3:0] be;
    logic [31:0] wd, rd;
    lat = 0; acc = 0; sawDone = 0; sawErr = 0; sawEn = 0; be = '0; wd = '0;
    @(negedge clk);
    rw = v.rw; size = v.size; unsign = v.uns; addr = v.addr; wdata = v.wdata;
    req = 1'b1; mem_moc = 1'b0;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk);
      @(negedge clk);
      req = 1'b0;
      if (v.t4 ? memEn1 : memEn0) begin
        if (!sawEn) begin
          be = v.t4 ? memBe1 : memBe0;
          wd = v.t4 ? memWdata1 : memWdata0;
        end
        sawEn = 1'b1;
        mem_moc = (acc == v.waits);
        acc++;
      end else begin
        mem_moc = 1'b0;
      end
      if (v.t4 ? (done1 || err1) : (done0 || err0)) begin
        sawDone = v.t4 ? done1 : done0;
        sawErr  = v.t4 ? err1 : err0;
        lat = k;
        break;
      end
    end
    rd = v.t4 ? rdata1 : rdata0;
    chk($sformatf("row%0d_done", idx), 64'(sawDone), 64'(v.expDone));
    chk($sformatf("row%0d_err", idx), 64'(sawErr), 64'(v.expErr));
    chk($sformatf("row%0d_latency", idx), 64'(lat), 64'(v.expLat));
    chk($sformatf("row%0d_rdata", idx), 64'(rd), 64'(v.expRdata));
    chk($sformatf("row%0d_mem_en_seen", idx), 64'(sawEn), 64'(v.expEn));
    if (v.expEn) begin
      chk($sformatf("row%0d_mem_be", idx), 64'(be), 64'(v.expBe));
      chk($sformatf("row%0d_mem_wdata", idx), 64'(wd), 64'(v.expWdata));
    end
    waitIdle();
  endtask

  initial begin
    int nDone, nEn, nPulse;

    // reset state
    #12;
    chk("rst_busy", 64'(busy0), 64'd0);
    chk("rst_done_err", 64'({done0, err0}), 64'd0);
    chk("rst_rdata", 64'(rdata0), 64'd0);
    chk("rst_mem_en", 64'(memEn0), 64'd0);
    chk("rst_mem_rw", 64'(memRw0), 64'd0);
    chk("rst_mem_addr", 64'(memAddr0), 64'd0);
    chk("rst_mem_wdata", 64'(memWdata0), 64'd0);
    chk("rst_mem_be", 64'(memBe0), 64'd0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);

`ifdef MAU_BIG_ENDIAN_EN
    //            rw   sz     u  addr      wdata          w   t4 D  E  En lat rdata          be       wdata
    vecs.push_back(mk(1, 2'b10, 0, 32'h100, 32'h0,         0,  0, 1, 0, 1, 3, 32'h80FF1234, 4'b1111, 32'h0));
    vecs.push_back(mk(1, 2'b00, 0, 32'h100, 32'h0,         0,  0, 1, 0, 1, 3, 32'hFFFFFF80, 4'b1000, 32'h0));
    vecs.push_back(mk(1, 2'b00, 1, 32'h103, 32'h0,         0,  0, 1, 0, 1, 3, 32'h00000034, 4'b0001, 32'h0));
    vecs.push_back(mk(1, 2'b01, 0, 32'h102, 32'h0,         0,  0, 1, 0, 1, 3, 32'h00001234, 4'b0011, 32'h0));
    vecs.push_back(mk(0, 2'b01, 0, 32'h100, 32'hCAFEBEEF,  2,  0, 1, 0, 1, 5, 32'h00001234, 4'b1100, 32'hBEEF0000));
    vecs.push_back(mk(1, 2'b01, 0, 32'h101, 32'h0,         0,  0, 0, 1, 0, 2, 32'h00001234, 4'b0000, 32'h0));
    vecs.push_back(mk(1, 2'b10, 0, 32'h100, 32'h0,         99, 1, 0, 1, 1, 6, 32'h00001234, 4'b1111, 32'h0));
`else
    vecs.push_back(mk(1, 2'b10, 0, 32'h100, 32'h0,         0,  0, 1, 0, 1, 3, 32'h80FF1234, 4'b1111, 32'h0));
    vecs.push_back(mk(1, 2'b00, 0, 32'h102, 32'h0,         0,  0, 1, 0, 1, 3, 32'hFFFFFFFF, 4'b0100, 32'h0));
    vecs.push_back(mk(1, 2'b00, 1, 32'h102, 32'h0,         0,  0, 1, 0, 1, 3, 32'h000000FF, 4'b0100, 32'h0));
    vecs.push_back(mk(1, 2'b00, 0, 32'h101, 32'h0,         0,  0, 1, 0, 1, 3, 32'h00000012, 4'b0010, 32'h0));
    vecs.push_back(mk(1, 2'b01, 0, 32'h102, 32'h0,         0,  0, 1, 0, 1, 3, 32'hFFFF80FF, 4'b1100, 32'h0));
    vecs.push_back(mk(1, 2'b01, 0, 32'h101, 32'h0,         0,  0, 0, 1, 0, 2, 32'hFFFF80FF, 4'b0000, 32'h0));
    vecs.push_back(mk(0, 2'b00, 0, 32'h103, 32'h123456AB,  4,  0, 1, 0, 1, 7, 32'hFFFF80FF, 4'b1000, 32'hAB000000));
    vecs.push_back(mk(1, 2'b11, 0, 32'h100, 32'h0,         0,  0, 0, 1, 0, 2, 32'hFFFF80FF, 4'b0000, 32'h0));
    vecs.push_back(mk(1, 2'b10, 0, 32'h102, 32'h0,         0,  0, 0, 1, 0, 2, 32'hFFFF80FF, 4'b0000, 32'h0));
    vecs.push_back(mk(1, 2'b01, 1, 32'h100, 32'h0,         1,  0, 1, 0, 1, 4, 32'h00001234, 4'b0011, 32'h0));
    vecs.push_back(mk(1, 2'b10, 0, 32'h100, 32'h0,         99, 1, 0, 1, 1, 6, 32'h00001234, 4'b1111, 32'h0));
    vecs.push_back(mk(0, 2'b01, 0, 32'h102, 32'hCAFEBEEF,  0,  0, 1, 0, 1, 3, 32'h00001234, 4'b1100, 32'hBEEF0000));
`endif

    foreach (vecs[i]) runVec(i, vecs[i]);

    // reset in the middle of an access
    @(negedge clk);
    rw = 1'b1; size = 2'b10; unsign = 1'b0; addr = 32'h100; req = 1'b1; mem_moc = 1'b0;
    @(negedge clk);
    req = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("midrst_in_access", 64'(memEn0), 64'd1);
    reset = 1'b0;
    #1;
    chk("midrst_mem_en", 64'(memEn0), 64'd0);
    chk("midrst_busy", 64'(busy0), 64'd0);
    chk("midrst_rdata", 64'(rdata0), 64'd0);
    @(negedge clk);
    reset = 1'b1;
    nPulse = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (done0 || err0 || done1 || err1 || memEn0) nPulse++;
    end
    chk("midrst_no_pulse", 64'(nPulse), 64'd0);

    // req held high: one access per IDLE visit, four edges each
    @(negedge clk);
    rw = 1'b1; size = 2'b10; unsign = 1'b0; addr = 32'h100; mem_moc = 1'b1; req = 1'b1;
    nDone = 0; nEn = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (done0) nDone++;
      if (memEn0) nEn++;
    end
    req = 1'b0;
    chk("held_req_dones", 64'(nDone), 64'd5);
    chk("held_req_accesses", 64'(nEn), 64'd5);
    chk("held_req_rdata", 64'(rdata0), 64'(MEM_WORD));
    waitIdle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nBad);
    $finish;
  end

endmodule
